// File: rtl/controller_in_pkg_hdl.sv
// controller_in_pkg_hdl: record layout and widths shared by the capture block
package controller_in_pkg_hdl;
  localparam int DATA_W_DEF = 16;
  localparam int CC_W       = 3;
  localparam int FLAG_W     = 1;
  localparam int REC_W      = 3*DATA_W_DEF + 2*CC_W + 2*FLAG_W;
  typedef struct packed {
    logic                  complete_data;
    logic                  complete_instr;
    logic [DATA_W_DEF-1:0] ir;
    logic [CC_W-1:0]       nzp;
    logic [CC_W-1:0]       psr;
    logic [DATA_W_DEF-1:0] ir_exec;
    logic [DATA_W_DEF-1:0] imem_dout;
  } rec_t;
  function automatic int rec_w(input int dw);
    return 3*dw + 2*CC_W + 2*FLAG_W;
  endfunction
endpackage

// File: rtl/controller_in_fifo.sv
// controller_in_fifo: first-word-fall-through FIFO, head reads zero when empty
module controller_in_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q;
  // pointers wrap naturally because DEPTH is a power of two; clr wins over push/pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clr) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= push ? wptr_q + AW'(1) : wptr_q;
      rptr_q  <= pop ? rptr_q + AW'(1) : rptr_q;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end
  // storage is not reset; the head is masked while empty instead
  always_ff @(posedge clk) begin
    if (push && !clr) mem[wptr_q] <= din;
  end
  assign valid = count_q != '0;
  assign dout  = valid ? mem[rptr_q] : '0;
  assign count = count_q;
endmodule

// File: rtl/controller_in_capture.sv
// controller_in_capture: timestamped capture of controller inputs into a FIFO
module controller_in_capture
  import controller_in_pkg_hdl::*;
#(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16,
  parameter int MODE   = 0
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      clr,
  input  logic                      complete_data,
  input  logic                      complete_instr,
  input  logic [DATA_W-1:0]         IR,
  input  logic [DATA_W-1:0]         IR_Exec,
  input  logic [DATA_W-1:0]         IMem_dout,
  input  logic [2:0]                NZP,
  input  logic [2:0]                psr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [3*DATA_W+7:0]       out_rec,
  output logic [TS_W-1:0]           out_ts,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      overflow,
  output logic [7:0]                drop_cnt
);
  localparam int RW = rec_w(DATA_W);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [RW-1:0]      cur, last_q, last_d;
  logic               first_q, first_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         drop_q, drop_d;
  logic               attempt, pop, push, full, drop;
  logic [RW+TS_W-1:0] head;
  assign cur     = {complete_data, complete_instr, IR, NZP, psr, IR_Exec, IMem_dout};
  assign full    = count == CW'(DEPTH);
  assign pop     = out_valid && out_ready && !clr;
  assign attempt = en && !clr && (MODE == 0 || first_q || cur != last_q);
  assign push    = attempt && (!full || pop);
  assign drop    = attempt && full && !pop;
  // next-state for timestamp, change detector and drop statistics
  always_comb begin
    ts_d       = clr ? '0 : ts_q + TS_W'(1);
    first_d    = clr || (first_q && !attempt);
    last_d     = attempt ? cur : last_q;
    overflow_d = clr ? 1'b0 : overflow_q || drop;
    drop_d     = clr ? 8'd0 : (drop && drop_q != 8'hFF) ? drop_q + 8'd1 : drop_q;
  end
  // capture-side state, cleared asynchronously by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ts_q       <= '0;
      first_q    <= 1'b1;
      last_q     <= '0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      ts_q       <= ts_d;
      first_q    <= first_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end
  controller_in_fifo #(.W(RW + TS_W), .DEPTH(DEPTH)) u_fifo (
    .clk   (clock),
    .rst_n (reset),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   ({cur, ts_q}),
    .dout  (head),
    .valid (out_valid),
    .count (count)
  );
  assign out_rec  = head[RW+TS_W-1:TS_W];
  assign out_ts   = head[TS_W-1:0];
  assign overflow = overflow_q;
  assign drop_cnt = drop_q;
endmodule

// File: tb/tb_controller_in_capture.sv
// tb_controller_in_capture: table, directed and random checks of both capture modes
module tb_controller_in_capture;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset, en, clr, rdy, cd, ci;
  logic [15:0] ir, ire, imem;
  logic [2:0]  nzp, psr;
  logic        valid [2];
  logic [55:0] rec [2];
  logic [15:0] ts [2];
  logic [3:0]  cnt [2];
  logic        ovf [2];
  logic [7:0]  dc [2];
  int total = 0;
  int bad = 0;
  logic [71:0] mq [2][$];
  logic        m_ovf [2];
  int          m_dc [2];
  logic [15:0] m_ts [2];
  logic        m_first [2];
  logic [55:0] m_last [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    controller_in_capture #(.DATA_W(16), .DEPTH(8), .TS_W(16), .MODE(g)) u_dut (
      .clock(clk), .reset(reset), .en(en), .clr(clr),
      .complete_data(cd), .complete_instr(ci),
      .IR(ir), .IR_Exec(ire), .IMem_dout(imem), .NZP(nzp), .psr(psr),
      .out_valid(valid[g]), .out_ready(rdy), .out_rec(rec[g]), .out_ts(ts[g]),
      .count(cnt[g]), .overflow(ovf[g]), .drop_cnt(dc[g])
    );
  end

  task automatic chk(input string name, input int m, input logic [71:0] a, input logic [71:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s[mode%0d] got=%0h exp=%0h t=%0t", name, m, a, e, $time);
    end
  endtask

  function automatic logic [55:0] cur_in();
    return {cd, ci, ir, nzp, psr, ire, imem};
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mq[m].delete();
      m_ovf[m] = 1'b0;
      m_dc[m] = 0;
      m_ts[m] = '0;
      m_first[m] = 1'b1;
      m_last[m] = '0;
    end
  endtask

  task automatic step();
    logic [55:0] c;
    c = cur_in();
    for (int m = 0; m < 2; m++) begin
      bit pop_m;
      pop_m = mq[m].size() != 0 && rdy;
      if (clr) begin
        mq[m].delete();
        m_ovf[m] = 1'b0;
        m_dc[m] = 0;
        m_ts[m] = '0;
        m_first[m] = 1'b1;
      end else begin
        bit att;
        att = en && (m == 0 || m_first[m] || c != m_last[m]);
        if (pop_m) void'(mq[m].pop_front());
        if (att) begin
          m_first[m] = 1'b0;
          m_last[m] = c;
          if (mq[m].size() < 8) mq[m].push_back({c, m_ts[m]});
          else begin
            m_ovf[m] = 1'b1;
            if (m_dc[m] < 255) m_dc[m]++;
          end
        end
        m_ts[m] = m_ts[m] + 16'd1;
      end
    end
    @(posedge clk);
    #1;
    for (int m = 0; m < 2; m++) begin
      chk("valid", m, 72'(valid[m]), 72'(mq[m].size() != 0));
      chk("count", m, 72'(cnt[m]), 72'(mq[m].size()));
      chk("overflow", m, 72'(ovf[m]), 72'(m_ovf[m]));
      chk("drop_cnt", m, 72'(dc[m]), 72'(m_dc[m]));
      if (mq[m].size() != 0) begin
        chk("rec", m, 72'(rec[m]), 72'(mq[m][0][71:16]));
        chk("ts", m, 72'(ts[m]), 72'(mq[m][0][15:0]));
      end
    end
  endtask

  task automatic reset_checks(input string name);
    for (int m = 0; m < 2; m++) begin
      chk({name, "_valid"}, m, 72'(valid[m]), 72'(0));
      chk({name, "_count"}, m, 72'(cnt[m]), 72'(0));
      chk({name, "_ovf"}, m, 72'(ovf[m]), 72'(0));
      chk({name, "_dc"}, m, 72'(dc[m]), 72'(0));
      chk({name, "_rec"}, m, 72'(rec[m]), 72'(0));
      chk({name, "_ts"}, m, 72'(ts[m]), 72'(0));
    end
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    #1 reset_checks("async_rst");
    model_reset();
    @(posedge clk);
    #1 reset_checks("hold_rst");
    #2 reset = 1'b1;
  endtask

  typedef struct {
    logic        en, clr, rdy;
    logic [15:0] ir;
    int          c0, c1;
    logic [15:0] hir;
  } vec_t;
  vec_t tbl [9];

  initial begin
    tbl[0] = '{1, 0, 0, 16'h1234, 1, 1, 16'h1234};
    tbl[1] = '{1, 0, 0, 16'h1235, 2, 2, 16'h1234};
    tbl[2] = '{1, 0, 0, 16'h1236, 3, 3, 16'h1234};
    tbl[3] = '{0, 0, 0, 16'h1236, 3, 3, 16'h1234};
    tbl[4] = '{1, 0, 0, 16'h1236, 4, 3, 16'h1234};
    tbl[5] = '{1, 0, 1, 16'h1236, 4, 2, 16'h1235};
    tbl[6] = '{0, 0, 1, 16'h1236, 3, 1, 16'h1236};
    tbl[7] = '{1, 1, 0, 16'h1236, 0, 0, 16'h0000};
    tbl[8] = '{1, 0, 0, 16'h1236, 1, 1, 16'h1236};
    reset = 1'b0; en = 0; clr = 0; rdy = 0; cd = 0; ci = 0;
    ir = '0; ire = '0; imem = '0; nzp = '0; psr = '0;
    model_reset();
    @(posedge clk);
    #1 reset_checks("por");
    #2 reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      en = tbl[i].en; clr = tbl[i].clr; rdy = tbl[i].rdy; ir = tbl[i].ir;
      step();
      chk($sformatf("tbl%0d_count", i), 0, 72'(cnt[0]), 72'(tbl[i].c0));
      chk($sformatf("tbl%0d_count", i), 1, 72'(cnt[1]), 72'(tbl[i].c1));
      if (tbl[i].c0 != 0) chk($sformatf("tbl%0d_head_ir", i), 0, 72'(rec[0][53:38]), 72'(tbl[i].hir));
    end
    en = 0; clr = 1; step(); clr = 0;
    en = 1; rdy = 0; ir = 16'h5020;
    for (int i = 0; i < 5; i++) step();
    ir = 16'h0E02; step(); en = 0;
    chk("change_only_count", 1, 72'(cnt[1]), 72'(2));
    chk("every_cycle_count", 0, 72'(cnt[0]), 72'(6));
    chk("change_only_head", 1, 72'(rec[1][53:38]), 72'(16'h5020));
    clr = 1; step(); clr = 0;
    en = 1;
    for (int i = 0; i < 10; i++) begin ir = 16'(i); step(); end
    chk("fill_count", 0, 72'(cnt[0]), 72'(8));
    chk("fill_ovf", 0, 72'(ovf[0]), 72'(1));
    chk("fill_drops", 0, 72'(dc[0]), 72'(2));
    rdy = 1;
    for (int i = 0; i < 5; i++) begin ir = 16'(i + 100); step(); end
    chk("full_stream_count", 0, 72'(cnt[0]), 72'(8));
    chk("full_stream_drops", 0, 72'(dc[0]), 72'(2));
    en = 0;
    for (int i = 0; i < 3; i++) step();
    chk("pre_clr_count", 0, 72'(cnt[0]), 72'(5));
    chk("pre_clr_ovf", 0, 72'(ovf[0]), 72'(1));
    clr = 1; en = 1; step(); clr = 0; en = 0; rdy = 0;
    chk("clr_count", 0, 72'(cnt[0]), 72'(0));
    chk("clr_ovf", 0, 72'(ovf[0]), 72'(0));
    chk("clr_drops", 0, 72'(dc[0]), 72'(0));
    chk("clr_valid", 0, 72'(valid[0]), 72'(0));
    en = 1;
    for (int i = 0; i < 308; i++) begin ir = 16'(i); step(); end
    chk("sat_drops", 0, 72'(dc[0]), 72'(255));
    clr = 1; step(); clr = 0;
    for (int i = 0; i < 4; i++) begin ir = 16'(i + 7); step(); end
    chk("pre_rst_count", 0, 72'(cnt[0]), 72'(4));
    do_reset();
    ir = 16'hBEEF; step();
    chk("post_rst_ts", 0, 72'(ts[0]), 72'(0));
    ir = 16'hBEF0; step();
    chk("post_rst_count", 0, 72'(cnt[0]), 72'(2));
    for (int i = 0; i < 2500; i++) begin
      en = $urandom_range(0, 3) != 0;
      rdy = $urandom_range(0, 1);
      clr = $urandom_range(0, 63) == 0;
      ir = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) nzp = 3'($urandom);
      if ($urandom_range(0, 7) == 0) psr = 3'($urandom);
      if ($urandom_range(0, 9) == 0) {cd, ci} = 2'($urandom);
      if ($urandom_range(0, 15) == 0) ire = 16'($urandom);
      if ($urandom_range(0, 15) == 0) imem = 16'($urandom);
      if ($urandom_range(0, 499) == 0) do_reset();
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
